// File: rtl/data_mem_pkg.sv
// Shared types for the load/store data memory: access sizes, error codes
// and the size-to-byte-count helper used by the lane steering logic.
package data_mem_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_SIZE     = 2'd3
  } mem_err_e;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/data_mem_bank.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables and a registered
// read port. The array is deliberately not reset.
module data_mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic [IDX_W-1:0]        addr,
  input  logic                    rd_en,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-masked write and registered read; read data holds while rd_en is low
  always_ff @(posedge clock) begin
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (wr_be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store data memory for the MEM stage. Decodes access errors, steers
// store bytes into lanes, and returns one registered response per request.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// resp_valid and resp_ready are both high. req_ready = !resp_valid ||
// resp_ready, so the single response slot is refilled on the same edge it
// drains, and resp_valid/resp_rdata/resp_err hold stable until taken.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(NB);
  localparam int IDX_W   = ADDR_WIDTH - OFF_W;
  localparam int BANK_W  = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [IDX_W-1:0]      word_idx;
  logic [OFF_W-1:0]      offset;
  logic [3:0]            nbytes;
  mem_err_e              req_err;
  logic                  accept;
  logic                  req_ok;
  logic [NB-1:0]         lane_mask;
  logic [NB-1:0]         wr_be;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] bank_rdata;

  // Response slot contents
  logic                  resp_load;
  logic [OFF_W-1:0]      resp_off;
  logic [1:0]            resp_size;
  logic                  resp_uns;

  assign word_idx  = req_addr[ADDR_WIDTH-1:OFF_W];
  assign offset    = req_addr[OFF_W-1:0];
  assign nbytes    = size_bytes(req_size);
  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign req_ok    = (req_err == ERR_NONE);

  // Error decode in priority order: illegal size, misaligned, out of range
  always_comb begin
    req_err = ERR_NONE;
    if (req_size == DWORD && DATA_WIDTH == 32)
      req_err = ERR_SIZE;
    else if (|(4'(offset) & (nbytes - 4'd1)))
      req_err = ERR_MISALIGN;
    else if (32'(word_idx) >= DEPTH_U)
      req_err = ERR_RANGE;
  end

  // Store lanes: size_bytes ones shifted up by the byte offset; faults and loads write nothing
  assign lane_mask = (NB'(1) << nbytes) - NB'(1);
  assign wr_be     = (accept && req_ok && req_write) ? (lane_mask << offset) : '0;
  assign wdata_sh  = req_wdata << {offset, 3'b000};
  assign rd_en     = accept && req_ok && !req_write;

  data_mem_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_bank (
    .clock (clock),
    .addr  (word_idx[BANK_W-1:0]),
    .rd_en (rd_en),
    .wr_be (wr_be),
    .wdata (wdata_sh),
    .rdata (bank_rdata)
  );

  // Response register: load on accept, clear valid once taken with nothing new behind it
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      resp_valid <= 1'b0;
      resp_err   <= ERR_NONE;
      resp_load  <= 1'b0;
      resp_off   <= '0;
      resp_size  <= '0;
      resp_uns   <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err   <= req_err;
      resp_load  <= req_ok && !req_write;
      resp_off   <= offset;
      resp_size  <= req_size;
      resp_uns   <= req_unsigned;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Load extension from the held bank word; a full-width mask makes extension a no-op
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext_mask;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [6:0]            nbits;
  logic                  sign_bit;

  always_comb begin
    shifted  = bank_rdata >> {resp_off, 3'b000};
    nbits    = {size_bytes(resp_size), 3'b000};
    ext_mask = (DATA_WIDTH'(1) << nbits) - DATA_WIDTH'(1);
    sign_bit = |(shifted & ext_mask & ~(ext_mask >> 1));
    load_ext = shifted & ext_mask;
    if (!resp_uns && sign_bit) load_ext = load_ext | ~ext_mask;
  end

  assign resp_rdata = resp_load ? load_ext : '0;

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised load/store data memory for the core's MEM stage, successor to the plain word-wide data RAM. It accepts byte-addressed load/store requests of byte, halfword, word (and doubleword at 64-bit width) size over a valid/ready handshake. It steers byte lanes, sign- or zero-extends load data, and flags misaligned, out-of-range and illegal-size accesses. It returns one registered response per request with backpressure.

## Interface
- ADDR_WIDTH, 14: byte-address width of req_addr.
- DATA_WIDTH, 32: memory word width; legal values 32 or 64.
- DEPTH, 4096: number of DATA_WIDTH words; must satisfy DEPTH*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.

- clock  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 doubleword.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (bits [8*size_bytes-1:0] used).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults.
- resp_err  out  2  0 none, 1 misaligned, 2 out of range, 3 illegal size.

## Operation
- Accept = req_valid && req_ready. req_ready = !resp_valid || resp_ready (combinational; one response register, full-throughput pass-through).
- Word index = req_addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; byte offset = low log2(DATA_WIDTH/8) bits.
- Error check on accept, priority: illegal size (size 3 with DATA_WIDTH 32) > misaligned (offset not a multiple of size_bytes) > out of range (word index >= DEPTH).
- Faulted request: no memory write, resp_rdata = 0, resp_err set, still produces exactly one response.
- Store: byte enables = size_bytes ones shifted by offset; wdata replicated/shifted into lanes; only enabled bytes change.
- Load: read word, shift right by 8*offset, mask to size, sign-extend from top loaded bit unless req_unsigned; req_unsigned ignored when size equals full width.
- Store response: resp_rdata = 0, resp_err = 0 on success.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (reset_L low, any time, async): resp_valid = 0, resp_rdata = 0, resp_err = 0; req_ready therefore 1. In-flight response discarded. A store accepted on the same edge that reset asserts is not guaranteed to commit.
- Latency: request accepted at edge N -> resp_valid high after edge N, data/err valid with it. Store commits at edge N.
- Back-to-back: new request accepted every cycle while resp_ready = 1.
- Backpressure: resp_valid && !resp_ready -> req_ready = 0; resp_valid, resp_rdata and resp_err hold stable until taken.
- Load following a store to the same address in the next cycle returns the new data (write at edge N, read at edge N+1).
- resp_valid drops after the edge where resp_ready = 1 and no new request was accepted.

## Structure
- Package data_mem_pkg: enum mem_size_e (BYTE, HALF, WORD, DWORD), enum mem_err_e (ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_SIZE), function for size-to-byte-count.
- Sub-module data_mem_bank: DEPTH x DATA_WIDTH array with per-byte active-high write enables and registered read port, no reset on the array.
- Top: handshake, error decode, lane steering, response register, load extension.

## Test plan
- Reset: hold reset_L low mid-response -> resp_valid = 0, resp_err = 0, req_ready = 1 immediately; resp_rdata = 0.
- SW 0xDEADBEEF to 0x10, then LB 0x13 -> 0xFFFFFFDE, LBU 0x13 -> 0x000000DE, LH 0x10 -> 0xFFFFBEEF, LHU 0x12 -> 0x0000DEAD, LW 0x10 -> 0xDEADBEEF.
- SB 0x55 to 0x11 after the above, then LW 0x10 -> 0xDEAD55EF (other bytes preserved).
- LH at 0x11 -> resp_err 1, rdata 0. SW at byte address 4*DEPTH -> resp_err 2, no memory change. size 3 at DATA_WIDTH 32 -> resp_err 3.
- Backpressure: issue 4 back-to-back loads with resp_ready low for 3 cycles on the 2nd response -> req_ready low for those cycles, response held stable, all 4 responses in order, none dropped or duplicated.
- DATA_WIDTH 64: SD 0x0123456789ABCDEF at 0x8, LW 0xC -> 0x0000000001234567, LW 0x8 -> 0xFFFFFFFF89ABCDEF.
